// File: rtl/apb_cmd_master.sv
// Command-to-APB master bridge: one outstanding transfer,
// misaligned commands answered locally with an error.
module apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA
);

  localparam int ALIGN_BITS = $clog2(APB_DATA_WIDTH / 8);
  // Mask form keeps ALIGN_BITS == 0 (8-bit bus) legal.
  localparam logic [APB_ADDR_WIDTH-1:0] LP_ALIGN_MASK =
    APB_ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t r_state;
  logic   w_accept;
  logic   w_misaligned;

  assign cmd_ready    = (r_state == S_IDLE);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_misaligned = |(cmd_addr & LP_ALIGN_MASK);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_misaligned) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              r_state   <= S_RESP;
            end else begin
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PADDR   <= cmd_addr;
              PWRITE  <= cmd_write;
              PWDATA  <= cmd_write ? cmd_wdata : '0;
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: cycle-exact
// checks of APB phases, responses and reset.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_master dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PRDATA    (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic cmd(input logic w,
                     input logic [31:0] a,
                     input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    step();
    step();
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    PRESET = 1'b0;
    step();
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // write 0x10, zero wait states
    cmd(1'b1, 32'h10, 32'hDEADBEEF);
    step();
    cmd_valid = 1'b0;
    chk("w_setup_psel", 64'(PSEL), 64'd1);
    chk("w_setup_pen", 64'(PENABLE), 64'd0);
    chk("w_setup_paddr", 64'(PADDR), 64'h10);
    chk("w_setup_pwdata", 64'(PWDATA), 64'hDEADBEEF);
    chk("w_setup_pwrite", 64'(PWRITE), 64'd1);
    chk("w_setup_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("w_setup_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    chk("w_acc_psel", 64'(PSEL), 64'd1);
    chk("w_acc_pen", 64'(PENABLE), 64'd1);
    chk("w_acc_paddr", 64'(PADDR), 64'h10);
    chk("w_acc_pwdata", 64'(PWDATA), 64'hDEADBEEF);
    chk("w_acc_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    chk("w_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("w_rsp_err", 64'(rsp_err), 64'd0);
    chk("w_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("w_rsp_psel", 64'(PSEL), 64'd0);
    handshake();

    // read 0x24 with 3 wait states; noise on PRDATA/PSLVERR
    PREADY  = 1'b0;
    PRDATA  = 32'hFFFFFFFF;
    PSLVERR = 1'b1;
    cmd(1'b0, 32'h24, 32'h99999999);
    step();
    cmd_valid = 1'b0;
    chk("r_setup_paddr", 64'(PADDR), 64'h24);
    chk("r_setup_pwrite", 64'(PWRITE), 64'd0);
    chk("r_setup_pwdata", 64'(PWDATA), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r_acc_pen", 64'(PENABLE), 64'd1);
      chk("r_acc_psel", 64'(PSEL), 64'd1);
      chk("r_acc_paddr", 64'(PADDR), 64'h24);
      chk("r_acc_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h12345678;
    step();
    chk("r_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("r_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("r_rsp_err", 64'(rsp_err), 64'd0);
    handshake();

    // write with slave error
    PSLVERR = 1'b1;
    PRDATA  = 32'h55555555;
    cmd(1'b1, 32'h40, 32'h0BADF00D);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("e_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("e_rsp_err", 64'(rsp_err), 64'd1);
    chk("e_rsp_rdata", 64'(rsp_rdata), 64'd0);
    handshake();
    PSLVERR = 1'b0;

    // misaligned read
    cmd(1'b0, 32'h13, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("m_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("m_rsp_err", 64'(rsp_err), 64'd1);
    chk("m_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("m_psel", 64'(PSEL), 64'd0);
    chk("m_paddr_held", 64'(PADDR), 64'h40);
    chk("m_cmd_ready", 64'(cmd_ready), 64'd0);
    handshake();

    // backpressure with next command held
    PRDATA = 32'hCAFE0001;
    cmd(1'b0, 32'h8, 32'h0);
    step();
    cmd(1'b1, 32'h20, 32'h11112222);
    step();
    step();
    PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_psel", 64'(PSEL), 64'd0);
      chk("bp_rdata", 64'(rsp_rdata), 64'hCAFE0001);
      step();
    end
    handshake();
    step();
    cmd_valid = 1'b0;
    chk("bp_next_psel", 64'(PSEL), 64'd1);
    chk("bp_next_paddr", 64'(PADDR), 64'h20);
    chk("bp_next_pwrite", 64'(PWRITE), 64'd1);
    chk("bp_next_pwdata", 64'(PWDATA), 64'h11112222);
    step();
    step();
    chk("bp_next_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_next_rdata", 64'(rsp_rdata), 64'd0);
    handshake();

    // reset during ACCESS
    PREADY = 1'b0;
    cmd(1'b0, 32'h4, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    chk("ra_pen", 64'(PENABLE), 64'd1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("ra_psel", 64'(PSEL), 64'd0);
    chk("ra_pen_rst", 64'(PENABLE), 64'd0);
    chk("ra_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ra_paddr", 64'(PADDR), 64'd0);
    step();
    PRESET = 1'b0;
    PREADY = 1'b1;
    PRDATA = 32'hA5A5A5A5;
    step();
    chk("ra_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd(1'b0, 32'h0, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("ra2_psel", 64'(PSEL), 64'd1);
    step();
    step();
    chk("ra2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("ra2_rdata", 64'(rsp_rdata), 64'hA5A5A5A5);
    chk("ra2_err", 64'(rsp_err), 64'd0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
